// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: credit-limited sequential fetch into a variable-latency
// in-order memory, a registered {pc, data} FIFO toward decode, and redirect flush.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // the memory response channel has no ready and is always taken.

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   addr_q    [DEPTH];
  logic [AW-1:0] aq_rd, aq_wr;
  logic [CW-1:0] inflight, discard;

  logic [CW:0]   credit_used;
  logic          req_acc, resp_pop, resp_keep, fifo_pop;
  logic [CW-1:0] inflight_nxt;

  // Every in-flight request owns a FIFO slot, so responses never need backpressure.
  assign credit_used   = {1'b0, inflight} + {1'b0, count};
  assign mem_req_valid = !rst && (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign req_acc      = mem_req_valid && mem_req_ready;
  assign resp_pop     = mem_resp_valid && (inflight != '0);
  assign resp_keep    = resp_pop && (discard == '0) && !redirect_valid;
  assign fifo_pop     = inst_valid && inst_ready && !redirect_valid;
  assign inflight_nxt = inflight + CW'(req_acc) - CW'(resp_pop);

  assign inst_valid = (count != '0);
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_acc)  aq_wr <= aq_wr + 1'b1;
      if (resp_pop) aq_rd <= aq_rd + 1'b1;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        discard  <= inflight_nxt;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_acc) fetch_pc <= fetch_pc + 32'd4;
        if (resp_pop && (discard != '0)) discard <= discard - 1'b1;
        if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (resp_keep) wr_ptr <= wr_ptr + 1'b1;
        count <= count + CW'(resp_keep) - CW'(fifo_pop);
      end
    end
  end

  // Storage is qualified by the pointers and count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (req_acc) addr_q[aq_wr] <= fetch_pc;
    if (resp_keep) begin
      fifo_pc[wr_ptr]   <= addr_q[aq_rd];
      fifo_data[wr_ptr] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: queue-based model checked every cycle, an in-order
// latency memory, and directed scenarios with hand-computed sequences.
module tb_inst_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  // model: fetch pointer, outstanding addresses, buffered {pc, data}, stale count
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_aq[$];
  logic [63:0] exp_q[$];
  int          m_discard = 0;

  // memory environment and observation logs
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_data[$];
  int          cons_cyc[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic env_reset();
    m_fetch = RESET_PC;
    m_aq.delete();
    exp_q.delete();
    m_discard = 0;
    mq_addr.delete();
    mq_due.delete();
    acc_log.delete();
    cons_pc.delete();
    cons_data.delete();
    cons_cyc.delete();
    cyc = 0;
  endtask

  // scoreboard compare: every cycle, after the active edge has settled
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_req_addr", mem_req_addr, RESET_PC);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
    end else begin
      check("req_valid", 32'(mem_req_valid), 32'((m_aq.size() + exp_q.size()) < DEPTH));
      check("req_addr", mem_req_addr, m_fetch);
      check("inst_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("inst_pc", inst_pc, exp_q[0][63:32]);
        check("inst_data", inst_data, exp_q[0][31:0]);
      end
    end
  end

  // driver: one cycle, called at a falling edge
  task automatic cycle_step(input logic mrdy, input logic irdy, input logic redir,
                            input logic [31:0] rpc);
    logic [31:0] a;
    logic        acc, pop, resp;
    mem_req_ready  = mrdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = word_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    if (mem_req_valid && mem_req_ready) begin
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + lat);
      acc_log.push_back(mem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      cons_pc.push_back(inst_pc);
      cons_data.push_back(inst_data);
      cons_cyc.push_back(cyc);
    end
    acc  = ((m_aq.size() + exp_q.size()) < DEPTH) && mrdy;
    pop  = (exp_q.size() > 0) && irdy;
    resp = mem_resp_valid;
    a    = '0;
    if (resp) begin
      checks++;
      if (m_aq.size() == 0) begin
        errors++;
        $display("FAIL resp_without_request: inflight 0 expected > 0 (cyc %0d)", cyc);
        resp = 1'b0;
      end else begin
        a = m_aq.pop_front();
      end
    end
    if (acc) m_aq.push_back(m_fetch);
    if (redir) begin
      exp_q.delete();
      m_discard = m_aq.size();
      m_fetch   = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (resp) begin
        if (m_discard > 0) m_discard--;
        else exp_q.push_back({a, mem_resp_data});
      end
      if (acc) m_fetch = m_fetch + 32'd4;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n, input logic mrdy, input logic irdy);
    for (int i = 0; i < n; i++) cycle_step(mrdy, irdy, 1'b0, 32'd0);
  endtask

  // asynchronous reset in the middle of a cycle, released on a falling edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("async_rst_req_addr", mem_req_addr, RESET_PC);
    check("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_inst_pc", inst_pc, 32'd0);
    check("async_rst_inst_data", inst_data, 32'd0);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    env_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b0;
    env_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_req_valid", 32'(mem_req_valid), 32'd1);
    check("release_req_addr", mem_req_addr, RESET_PC);

    // streaming, 1-cycle memory, decode always ready
    lat = 1;
    run(8, 1'b1, 1'b1);
    check("s1_cons_count", 32'(cons_pc.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("s1_cons_pc", cons_pc[i], 32'(4 * i));
      check("s1_cons_cyc", 32'(cons_cyc[i]), 32'(i + 2));
    end
    check("s1_acc2", acc_log[2], 32'h8);

    // decode stalled: FIFO fills, credit stops requests
    do_reset();
    lat = 1;
    run(6, 1'b1, 1'b0);
    check("s2_acc_count", 32'(acc_log.size()), 32'd4);
    check("s2_acc3", acc_log[3], 32'hC);
    check("s2_req_valid_low", 32'(mem_req_valid), 32'd0);
    check("s2_head_valid", 32'(inst_valid), 32'd1);
    check("s2_head_pc", inst_pc, 32'h0);
    run(8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) check("s2_drain_pc", cons_pc[i], 32'(4 * i));
    check("s2_resume_addr", acc_log[4], 32'h10);

    // 3 in flight at latency 3, redirect to unaligned 0x103
    do_reset();
    lat = 3;
    run(3, 1'b1, 1'b1);
    cycle_step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    check("s3_target_addr", mem_req_addr, 32'h100);
    run(10, 1'b1, 1'b1);
    check("s3_acc_after", acc_log[3], 32'h100);
    check("s3_first_pc", cons_pc[0], 32'h100);
    check("s3_first_data", cons_data[0], word_of(32'h100));
    check("s3_first_cyc", 32'(cons_cyc[0]), 32'd8);
    check("s3_second_pc", cons_pc[1], 32'h104);

    // redirect coinciding with pop, response and accept
    do_reset();
    lat = 1;
    run(3, 1'b1, 1'b1);
    cycle_step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("s4_inst_valid_low", 32'(inst_valid), 32'd0);
    check("s4_target_addr", mem_req_addr, 32'h200);
    run(6, 1'b1, 1'b1);
    check("s4_acc_stale", acc_log[3], 32'hC);
    check("s4_acc_target", acc_log[4], 32'h200);
    check("s4_cons1", cons_pc[1], 32'h4);
    check("s4_cons2", cons_pc[2], 32'h200);
    check("s4_cons2_cyc", 32'(cons_cyc[2]), 32'd6);
    check("s4_cons3", cons_pc[3], 32'h204);

    // wrap of the fetch address
    do_reset();
    lat = 1;
    cycle_step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run(7, 1'b1, 1'b1);
    check("s5_acc1", acc_log[1], 32'hFFFF_FFF8);
    check("s5_acc2", acc_log[2], 32'hFFFF_FFFC);
    check("s5_acc3", acc_log[3], 32'h0);
    check("s5_cons0", cons_pc[0], 32'hFFFF_FFF8);
    check("s5_cons1", cons_pc[1], 32'hFFFF_FFFC);
    check("s5_cons2", cons_pc[2], 32'h0);

    // reset while requests and words are in flight
    do_reset();
    check("s6_release_data", inst_data, 32'd0);
    lat = 2;
    run(8, 1'b1, 1'b1);
    check("s6_first_acc", acc_log[0], RESET_PC);
    check("s6_first_pc", cons_pc[0], 32'h0);
    check("s6_first_data", cons_data[0], word_of(32'h0));
    check("s6_first_cyc", 32'(cons_cyc[0]), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction fetch front end that replaces the combinational instruction-memory read in front of the CPU decode path. It generates sequential fetch addresses, issues them to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel, buffers returned words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. A redirect from the branch/jump resolution point flushes the buffer, discards stale in-flight responses and restarts fetch at the target.

## Interface
- DEPTH, 4: FIFO entries and also the maximum number of in-flight requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  pulse: restart fetch at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  word-aligned fetch address
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_resp_valid  in  1  response word valid; responses return in request order
- mem_resp_data  in  32  instruction word
- inst_valid  out  1  FIFO head valid
- inst_data  out  32  instruction at the FIFO head
- inst_pc  out  32  PC of the instruction at the FIFO head
- inst_ready  in  1  decode consumes the head this cycle

## Operation
- State:
  - fetch_pc (32)
  - FIFO of {pc, data} with DEPTH entries; count width clog2(DEPTH)+1
  - in-flight address queue of DEPTH entries
  - inflight counter
  - discard counter
- Credit rule: mem_req_valid = (inflight + count < DEPTH). mem_req_addr = fetch_pc.
- Request accept (mem_req_valid & mem_req_ready):
  - push fetch_pc into the address queue;
  - inflight +1;
  - fetch_pc += 4, modulo 2^32 (wraps from FFFF_FFFC to 0).
- Response (mem_resp_valid):
  - pop the address queue and decrement inflight.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: push {popped addr, mem_resp_data} into the FIFO.
  - A response is always accepted; the credit rule guarantees FIFO space.
- Consume (inst_valid & inst_ready): pop the FIFO head.
- Redirect (redirect_valid), which has priority over everything in the same cycle:
  - FIFO count becomes 0, and any pop that cycle is ignored;
  - fetch_pc = {redirect_pc[31:2], 2'b00};
  - discard = number of in-flight requests after this cycle's accept and response. A request accepted in the redirect cycle counts as stale. A response arriving in the redirect cycle is dropped.
- Outstanding stale requests still occupy credit until their responses return. New requests may issue while discard > 0.
- A mem_resp_valid with inflight = 0 is a protocol violation; the block ignores it. The bench asserts it never occurs.

## Timing
- Reset values (asserted asynchronously):
  - mem_req_valid=0 while rst=1, and mem_req_addr=RESET_PC;
  - inst_valid=0, inst_data=0, inst_pc=0;
  - all counters 0, fetch_pc=RESET_PC.
- First cycle after rst deasserts: mem_req_valid=1, mem_req_addr=RESET_PC.
- Request side:
  - mem_req_addr is stable while mem_req_valid=1 and not accepted.
  - Exception: the cycle after a redirect, the address changes to the target (retraction permitted). The instruction memory model honours this.
- Response side: earliest response is the cycle after acceptance.
- FIFO is registered. A word received in cycle t appears on inst_valid/inst_data/inst_pc at t+1.
- Minimum request-accept to inst_valid latency: 2 cycles.
- With inst_ready held at 1 and zero-wait memory, sustained throughput is 1 instruction per cycle.
- Simultaneous push and pop at any count, including full, is legal; count stays unchanged.
- The cycle after a redirect: inst_valid=0.
- Reset mid-operation clears everything. The instruction memory shares rst, so no pre-reset response arrives afterwards.

## Test plan
- Reset release, memory ready=1, 1-cycle latency, inst_ready=1:
  - requests 0x0, 0x4, 0x8, ...;
  - inst_pc sequence 0x0, 0x4, 0x8, ... back to back from cycle 2.
- inst_ready=0 with DEPTH=4:
  - exactly 4 requests issue, then mem_req_valid=0;
  - count=4, and inst_pc holds 0x0;
  - raising inst_ready drains 0x0..0xC in order, and fetching resumes at 0x10.
- Memory latency 3 with 3 requests in flight (0x0, 0x4, 0x8), then redirect to 0x103:
  - the next request is 0x100;
  - the 3 stale responses are dropped;
  - the first inst_pc delivered is 0x100.
- Redirect in the same cycle as a pop, a response and a request accept:
  - FIFO empties, inst_valid=0 next cycle;
  - both the responding word and the just-accepted request are discarded;
  - fetch restarts at the target.
- Redirect to 0xFFFF_FFF8: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in sequence.
- rst asserted mid-stream:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - after release, the first request is RESET_PC and no stale data appears on inst_data.
